// File: rtl/ntt_butterfly.sv
// ntt_butterfly: radix-2 NTT/INTT butterfly around one Montgomery multiplier.
//
// Contents (package first, then the multiplier, then the top):
//   ntt_pkg       - modulus constants (DATA_WIDTH, Q, Q_M, Q_K)
//   mo_mul        - pipelined Montgomery multiplier, res = a*b*2^-Q_K mod Q
//   ntt_butterfly - Cooley-Tukey (mode 0) / Gentleman-Sande (mode 1) butterfly
//
// ntt_butterfly ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   in_valid   operand set valid this cycle (no backpressure)
//   in_mode    0 = CT (forward NTT), 1 = GS (inverse NTT)
//   in_a/in_b  upper/lower coefficient, 0..Q-1
//   in_w       twiddle in Montgomery form (w*2^DATA_WIDTH mod Q), 0..Q-1
//   out_valid  result valid, exactly MUL_LAT+1 cycles after in_valid
//   out_mode   mode of the emerging result
//   out_x/y    results, 0..Q-1; held between valid results
//
// Optional build macro BFLY_DIV2_EN: in GS mode both outputs are halved mod Q
// in the final register stage (folds the INTT 1/2 scaling into each stage).
// Latency is unchanged and CT mode is unaffected.

package ntt_pkg;
  localparam int unsigned DATA_WIDTH = 12;
  localparam int unsigned Q          = 3329;
  // -Q^-1 mod 2^Q_K, used for the Montgomery quotient
  localparam int unsigned Q_M        = 3327;
  // Montgomery radix exponent, R = 2^Q_K
  localparam int unsigned Q_K        = 12;
endpackage

// mo_mul: Montgomery product res = a*b*R^-1 mod Q with a lazy final reduction,
// so res may equal Q exactly (never more). The operand flops live in the
// caller, so MUL_LAT counts the caller's operand register plus MUL_LAT-1
// internal stages here. MUL_LAT must be at least 4.
//   clk  clock
//   a/b  operands, 0..Q-1
//   res  product, 0..Q
module mo_mul
  import ntt_pkg::*;
#(
  parameter int unsigned MUL_LAT = 6
) (
  input  logic                  clk,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] res
);

  localparam int unsigned W   = DATA_WIDTH;
  localparam int unsigned PW  = 2 * W;
  localparam int unsigned SW  = 2 * W + 1;
  localparam int unsigned TW  = W + 1;
  localparam int unsigned Pad = MUL_LAT - 4;

  localparam logic [W-1:0]  QmW = W'(Q_M);
  localparam logic [SW-1:0] QS  = SW'(Q);
  localparam logic [TW-1:0] QT  = TW'(Q);

  logic [PW-1:0] prod_q;
  logic [PW-1:0] prod2_q;
  logic [W-1:0]  m_q;
  logic [SW-1:0] sum;
  logic [TW-1:0] t;
  logic [TW-1:0] lazy;
  logic [W-1:0]  r_q;

  // Stage A: full product. Stage B: quotient m = (p mod R) * Q_M mod R.
  always_ff @(posedge clk) begin
    prod_q  <= PW'(a) * PW'(b);
    prod2_q <= prod_q;
    m_q     <= prod_q[W-1:0] * QmW;
  end

  // Stage C: t = (p + m*Q) / R, exact division since the low bits cancel.
  // t < 2Q, so one subtraction when t > Q leaves 0..Q.
  always_comb begin
    sum  = SW'(prod2_q) + SW'(m_q) * QS;
    t    = TW'(sum >> Q_K);
    lazy = (t > QT) ? (t - QT) : t;
  end

  always_ff @(posedge clk) begin
    r_q <= W'(lazy);
  end

  if (Pad == 0) begin : g_nopad
    assign res = r_q;
  end else begin : g_pad
    logic [W-1:0] pad_q [Pad];
    always_ff @(posedge clk) begin
      pad_q[0] <= r_q;
      for (int i = 1; i < Pad; i++) begin
        pad_q[i] <= pad_q[i-1];
      end
    end
    assign res = pad_q[Pad-1];
  end

endmodule

module ntt_butterfly
  import ntt_pkg::*;
#(
  parameter int unsigned MUL_LAT = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_mode,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [DATA_WIDTH-1:0] in_w,
  output logic                  out_valid,
  output logic                  out_mode,
  output logic [DATA_WIDTH-1:0] out_x,
  output logic [DATA_WIDTH-1:0] out_y
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned TW = W + 1;
  localparam logic [TW-1:0] QT = TW'(Q);

  // Modular helpers: operands in 0..Q-1, one W+1 bit op plus one correction.
  function automatic logic [W-1:0] add_mod(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [TW-1:0] s;
    s = TW'(x) + TW'(y);
    return (s >= QT) ? W'(s - QT) : W'(s);
  endfunction

  // |x-y| < Q < 2^W, so bit W of the difference is the borrow.
  function automatic logic [W-1:0] sub_mod(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [TW-1:0] d;
    d = TW'(x) - TW'(y);
    return d[W] ? W'(d + QT) : W'(d);
  endfunction

  // Folds a lazy multiplier result of exactly Q (or anything >= Q) back below Q.
  function automatic logic [W-1:0] norm(input logic [W-1:0] v);
    return (TW'(v) >= QT) ? W'(TW'(v) - QT) : v;
  endfunction

`ifdef BFLY_DIV2_EN
  // v/2 mod Q: odd values become even after adding the (odd) modulus.
  function automatic logic [W-1:0] halve(input logic [W-1:0] v);
    return v[0] ? W'((TW'(v) + QT) >> 1) : (v >> 1);
  endfunction
`endif

  // Control pipeline: index k holds the op that entered k cycles ago.
  logic [MUL_LAT:1] vld_q;
  logic [MUL_LAT:1] mode_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      mode_q <= '0;
    end else begin
      vld_q  <= {vld_q[MUL_LAT-1:1], in_valid};
      mode_q <= {mode_q[MUL_LAT-1:1], in_mode};
    end
  end

  // Stage 1: both modes are prepared; the stage-1 mode picks which pair is used.
  logic [W-1:0] a1_q;
  logic [W-1:0] b1_q;
  logic [W-1:0] w1_q;
  logic [W-1:0] s1_q;
  logic [W-1:0] d1_q;

  always_ff @(posedge clk) begin
    a1_q <= in_a;
    b1_q <= in_b;
    w1_q <= in_w;
    s1_q <= add_mod(in_a, in_b);
    d1_q <= sub_mod(in_a, in_b);
  end

  logic [W-1:0] mul_op;
  logic [W-1:0] pass;
  logic [W-1:0] mul_res;

  always_comb begin
    mul_op = mode_q[1] ? d1_q : b1_q;
    pass   = mode_q[1] ? s1_q : a1_q;
  end

  mo_mul #(
    .MUL_LAT(MUL_LAT)
  ) u_mo_mul (
    .clk(clk),
    .a  (mul_op),
    .b  (w1_q),
    .res(mul_res)
  );

  // Upper operand (a for CT, s for GS) delayed to meet the multiplier result.
  logic [W-1:0] dl_q [MUL_LAT-1];

  always_ff @(posedge clk) begin
    dl_q[0] <= pass;
    for (int i = 1; i < MUL_LAT - 1; i++) begin
      dl_q[i] <= dl_q[i-1];
    end
  end

  // Final stage, selected by the mode that travelled alongside the data.
  logic [W-1:0] upper;
  logic [W-1:0] t_n;
  logic [W-1:0] ct_x;
  logic [W-1:0] ct_y;
  logic [W-1:0] gs_x;
  logic [W-1:0] gs_y;
  logic [W-1:0] x_d;
  logic [W-1:0] y_d;

  always_comb begin
    upper = dl_q[MUL_LAT-2];
    t_n   = norm(mul_res);
    ct_x  = add_mod(upper, t_n);
    ct_y  = sub_mod(upper, t_n);
`ifdef BFLY_DIV2_EN
    gs_x  = halve(upper);
    gs_y  = halve(t_n);
`else
    gs_x  = upper;
    gs_y  = t_n;
`endif
    x_d   = mode_q[MUL_LAT] ? gs_x : ct_x;
    y_d   = mode_q[MUL_LAT] ? gs_y : ct_y;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
    end else begin
      out_valid <= vld_q[MUL_LAT];
      if (vld_q[MUL_LAT]) begin
        out_mode <= mode_q[MUL_LAT];
        out_x    <= x_d;
        out_y    <= y_d;
      end
    end
  end

endmodule

// File: doc/ntt_butterfly.md
Name: ntt_butterfly

Overview:
- Radix-2 NTT/INTT butterfly that wraps one mo_mul instance and performs the modular add/subtract around it.
- Sits between the coefficient memory read path and write-back. It is the direct consumer of mo_mul's result and the producer of its operand in inverse mode.
- Supports Cooley-Tukey (forward NTT) and Gentleman-Sande (inverse NTT) per operation, with a fixed latency in both modes.
- Twiddles are supplied pre-scaled to Montgomery form (w·2^DATA_WIDTH mod Q).

Parameters:
- MUL_LAT, 6: clock latency of the instantiated mo_mul (a/b to result). It must match the mo_mul configuration selected in ntt_macro.svh.
- DATA_WIDTH, Q, Q_M, Q_K: taken from ntt_pkg, not overridable here.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  1  operand set valid this cycle
- in_mode  input  1  0 = CT (NTT), 1 = GS (INTT)
- in_a  input  DATA_WIDTH  upper coefficient, range 0..Q-1
- in_b  input  DATA_WIDTH  lower coefficient, range 0..Q-1
- in_w  input  DATA_WIDTH  twiddle in Montgomery form, range 0..Q-1
- out_valid  output  1  results valid
- out_mode  output  1  mode of the emerging result
- out_x  output  DATA_WIDTH  first result, range 0..Q-1
- out_y  output  DATA_WIDTH  second result, range 0..Q-1

Behaviour:
- Fully pipelined, no backpressure. One operation is accepted per cycle; in_valid=0 inserts a bubble.
- Latency L = MUL_LAT+1 in both modes: out_valid rises exactly L cycles after the in_valid cycle. Back-to-back inputs with alternating in_mode emerge back-to-back in order.
- CT path:
  - t = mo_mul(in_b, in_w), i.e. b·w mod Q.
  - in_a travels through an MUL_LAT-deep delay line.
  - Final register: out_x = (a+t) mod Q, out_y = (a−t) mod Q.
- GS path:
  - Stage 1 registers s = (a+b) mod Q and d = (a−b) mod Q. d feeds mo_mul together with w, which is delayed 1 cycle.
  - s travels through an MUL_LAT-deep delay line.
  - Output: out_x = s, out_y = mo_mul(d, w) normalised.
- Mode-aligned muxing:
  - The mo_mul operand mux is selected by the stage-1 mode.
  - The output mux is selected by the mode delayed to stage L. out_mode is that delayed mode.
- Arithmetic rules:
  - All add/subtract is done in DATA_WIDTH+1 bits with a single conditional ±Q correction.
  - mo_mul may return exactly Q, or a value below 2^DATA_WIDTH. The output stage must reduce any value ≥Q by one subtraction of Q before use, so outputs are never ≥Q.
- Bubbles: in bubble cycles the datapath may toggle. out_x/out_y hold their last valid value, with the registers enabled by the valid pipeline.
- Reset:
  - Asynchronously clears the valid/mode shift registers, out_valid, out_mode, out_x and out_y to 0.
  - Data delay lines need no reset.
  - Operations in flight at reset are discarded. The first post-reset in_valid produces out_valid after L cycles.
- Q sensitivity: edge values a=0, b=0, a=Q-1, b=Q-1 and w=0 must produce exact results; there is no overflow at 2Q-2.

Optional Feature:
BFLY_DIV2_EN
- Defined: in GS mode, both out_x and out_y are additionally halved mod Q: x even → x>>1, x odd → (x+Q)>>1. This folds the INTT 1/2 scaling into each stage.
- The halving sits in the final register stage, so latency is unchanged. CT mode is unaffected.
- Undefined: no halving logic is present.

Test Plan (ntt_pkg Q=3329, DATA_WIDTH=12, Montgomery one w=767):
- CT, a=5, b=1, w=767 → out_x=6, out_y=4, out_mode=0, L=MUL_LAT+1 cycles after input.
- CT, a=0, b=1, w=767 → out_y=3328. Then a=3328, b=1, w=767 → out_x=0 (wrap-around in both directions).
- GS, a=10, b=3, w=767 → out_x=13, out_y=7. Then a=3328, b=3328 → out_x=3327, out_y=0. With BFLY_DIV2_EN, a=10, b=3 gives out_x=1671, out_y=1668.
- Stream of 20 back-to-back random ops alternating CT/GS, with random bubbles → results match a golden model in order, with out_valid and out_mode aligned exactly.
- Assert rst for 1 cycle while 3 ops are in flight → outputs and out_valid go 0 immediately, no stale results appear, and the next op emerges after L cycles.
- w=0 in CT with a=1234, b=999 → out_x=out_y=1234. Also check that a mo_mul result of exactly Q is normalised (force via b=Q-1 sweep) → no output ≥3329.
